// File: rtl/cct_xyz_scheduler.sv
// cct_xyz_scheduler: round-robin front end that shares one CCT-to-XYZ converter
// among NUM_REQ requesters, with CCT clamping, a one-entry result cache and a
// conversion timeout.
//   clk, rst            : clock, asynchronous active-high reset
//   req_valid/req_cct   : per-requester request and packed 16-bit CCTs
//   req_ready           : one-hot accept of the round-robin winner (IDLE only)
//   cache_flush         : invalidates the cached result
//   conv_cct_out/valid  : clamped CCT and one-cycle launch pulse to converter
//   conv_xyz_*/valid    : converter Q16.16 result and strobe
//   rsp_valid           : one-hot one-cycle response strobe
//   rsp_xyz_*           : registered response data
//   rsp_timeout         : response carries an aborted conversion
//   busy                : high whenever not idle
module cct_xyz_scheduler #(
   parameter int NUM_REQ = 3,
   parameter int TIMEOUT = 64,
   parameter int CCT_MIN = 3000,
   parameter int CCT_MAX = 8000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    req_valid,
   input  logic [NUM_REQ*16-1:0] req_cct,
   output logic [NUM_REQ-1:0]    req_ready,
   input  logic                  cache_flush,
   output logic [15:0]           conv_cct_out,
   output logic                  conv_cct_valid,
   input  logic [31:0]           conv_xyz_x,
   input  logic [31:0]           conv_xyz_y,
   input  logic [31:0]           conv_xyz_z,
   input  logic                  conv_xyz_valid,
   output logic [NUM_REQ-1:0]    rsp_valid,
   output logic [31:0]           rsp_xyz_x,
   output logic [31:0]           rsp_xyz_y,
   output logic [31:0]           rsp_xyz_z,
   output logic                  rsp_timeout,
   output logic                  busy
);
   localparam int LW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        r_state, w_next;
   logic [LW-1:0] r_last, r_g, w_grant, w_idx;
   logic          w_found, w_hit, w_expire;
   logic [15:0]   w_sel, w_clamp, r_cct, r_cache_cct, r_conv_cct;
   logic          r_cache_valid, r_to;
   logic [31:0]   r_cache_x, r_cache_y, r_cache_z, r_x, r_y, r_z;
   logic [CW-1:0] r_cnt;

   // Round-robin search starting just after the previous winner.
   always_comb begin
      w_found = 1'b0;
      w_grant = '0;
      w_idx   = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         w_idx = LW'((int'(r_last) + k) % NUM_REQ);
         if (!w_found && req_valid[w_idx]) begin
            w_found = 1'b1;
            w_grant = w_idx;
         end
      end
   end

   assign w_sel    = req_cct[{w_grant, 4'b0000} +: 16];
   assign w_clamp  = (w_sel < 16'(CCT_MIN)) ? 16'(CCT_MIN) :
                     (w_sel > 16'(CCT_MAX)) ? 16'(CCT_MAX) : w_sel;
   // A flush in the lookup cycle must force a miss.
   assign w_hit    = r_cache_valid && !cache_flush && (r_cct == r_cache_cct);
   assign w_expire = (r_cnt == CW'(TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:   w_next = w_found ? S_LOOKUP : S_IDLE;
         S_LOOKUP: w_next = w_hit ? S_RESP : S_ISSUE;
         S_ISSUE:  w_next = S_WAIT;
         S_WAIT:   w_next = (conv_xyz_valid || w_expire) ? S_RESP : S_WAIT;
         default:  w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_last        <= LW'(NUM_REQ - 1);
         r_g           <= '0;
         r_cct         <= '0;
         r_conv_cct    <= '0;
         r_cache_valid <= 1'b0;
         r_cache_cct   <= '0;
         r_cache_x     <= '0;
         r_cache_y     <= '0;
         r_cache_z     <= '0;
         r_x           <= '0;
         r_y           <= '0;
         r_z           <= '0;
         r_to          <= 1'b0;
         r_cnt         <= '0;
      end else begin
         if (r_state == S_IDLE && w_found) begin
            r_g    <= w_grant;
            r_cct  <= w_clamp;
            r_last <= w_grant;
         end
         if (r_state == S_LOOKUP && w_hit) begin
            r_x  <= r_cache_x;
            r_y  <= r_cache_y;
            r_z  <= r_cache_z;
            r_to <= 1'b0;
         end
         // Loaded one cycle early so the CCT is already stable during the launch pulse.
         if (r_state == S_LOOKUP && !w_hit) r_conv_cct <= r_cct;
         if (r_state == S_ISSUE) r_cnt <= '0;
         if (r_state == S_WAIT) begin
            r_cnt <= r_cnt + CW'(1);
            if (conv_xyz_valid) begin
               r_x           <= conv_xyz_x;
               r_y           <= conv_xyz_y;
               r_z           <= conv_xyz_z;
               r_to          <= 1'b0;
               r_cache_x     <= conv_xyz_x;
               r_cache_y     <= conv_xyz_y;
               r_cache_z     <= conv_xyz_z;
               r_cache_cct   <= r_cct;
               r_cache_valid <= 1'b1;
            end else if (w_expire) begin
               r_x           <= '0;
               r_y           <= '0;
               r_z           <= '0;
               r_to          <= 1'b1;
               r_cache_valid <= 1'b0;
            end
         end
         // Flush overrides a fill in the same cycle.
         if (cache_flush) r_cache_valid <= 1'b0;
      end
   end

   assign req_ready      = (r_state == S_IDLE && w_found) ? (NUM_REQ'(1) << w_grant) : '0;
   assign rsp_valid      = (r_state == S_RESP) ? (NUM_REQ'(1) << r_g) : '0;
   assign conv_cct_valid = (r_state == S_ISSUE);
   assign conv_cct_out   = r_conv_cct;
   assign rsp_xyz_x      = r_x;
   assign rsp_xyz_y      = r_y;
   assign rsp_xyz_z      = r_z;
   assign rsp_timeout    = r_to;
   assign busy           = (r_state != S_IDLE);
endmodule

// File: tb/tb_cct_xyz_scheduler.sv
// tb_cct_xyz_scheduler: randomized transaction-level check of cct_xyz_scheduler
module tb_cct_xyz_scheduler;
   localparam int N = 3, TO = 64, CMIN = 3000, CMAX = 8000;

   logic            clk = 1'b0, rst;
   logic [N-1:0]    req_valid, req_ready, rsp_valid;
   logic [N*16-1:0] req_cct;
   logic            cache_flush, conv_cct_valid, conv_xyz_valid, rsp_timeout, busy;
   logic [15:0]     conv_cct_out;
   logic [31:0]     conv_xyz_x, conv_xyz_y, conv_xyz_z, rsp_xyz_x, rsp_xyz_y, rsp_xyz_z;

   int n_checks = 0, n_errors = 0;

   logic [N-1:0] pend;
   logic [15:0]  pcct [N];

   int          m_last;
   bit          m_cv;
   logic [15:0] m_ccct;
   logic [31:0] m_cx, m_cy, m_cz;

   always #5 clk = ~clk;

   cct_xyz_scheduler #(.NUM_REQ(N), .TIMEOUT(TO), .CCT_MIN(CMIN), .CCT_MAX(CMAX)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_cct(req_cct), .req_ready(req_ready),
      .cache_flush(cache_flush), .conv_cct_out(conv_cct_out), .conv_cct_valid(conv_cct_valid),
      .conv_xyz_x(conv_xyz_x), .conv_xyz_y(conv_xyz_y), .conv_xyz_z(conv_xyz_z),
      .conv_xyz_valid(conv_xyz_valid), .rsp_valid(rsp_valid), .rsp_xyz_x(rsp_xyz_x),
      .rsp_xyz_y(rsp_xyz_y), .rsp_xyz_z(rsp_xyz_z), .rsp_timeout(rsp_timeout), .busy(busy));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] clamp(input logic [15:0] v);
      return (int'(v) < CMIN) ? 16'(CMIN) : (int'(v) > CMAX) ? 16'(CMAX) : v;
   endfunction

   function automatic int rr(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++)
         if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 9))
         0: return 16'd0;
         1: return 16'd2999;
         2: return 16'd3000;
         3: return 16'd8000;
         4: return 16'd8001;
         5: return 16'd65535;
         6, 7: return 16'd5000;
         default: return 16'($urandom_range(3000, 8000));
      endcase
   endfunction

   task automatic drive();
      req_valid = pend;
      for (int i = 0; i < N; i++) req_cct[16*i +: 16] = pcct[i];
   endtask

   task automatic model_reset();
      m_last = N - 1;
      m_cv   = 0;
   endtask

   // One complete transaction: grant, lookup, optional conversion, response.
   // delay = WAIT cycles before the stub answers (>= TO means silent).
   task automatic do_txn(input int delay, input bit fl_lookup, input bit fl_fill,
                         input bit late, input bit gap);
      int g, last_k, i;
      bit hit, got;
      logic [15:0] c;
      logic [N-1:0] oh;
      logic [31:0] sx, sy, sz;
      @(negedge clk);
      conv_xyz_valid = 1'b0;
      cache_flush    = 1'b0;
      if (gap) begin
         pend = '0;
         drive();
         #1;
         chk("gap_busy", busy, 0);
         chk("gap_ready", req_ready, 0);
         @(negedge clk);
      end
      if (pend == '0) begin
         i = $urandom_range(0, N - 1);
         pend[i] = 1'b1;
         pcct[i] = pick();
      end
      drive();
      #1;
      g = rr(pend, m_last);
      oh = '0;
      oh[g] = 1'b1;
      c = clamp(pcct[g]);
      chk("grant_ready", req_ready, oh);
      chk("grant_busy", busy, 0);
      chk("grant_rsp", rsp_valid, 0);
      m_last = g;
      hit = m_cv && (c == m_ccct) && !fl_lookup;
      @(negedge clk);
      if ($urandom_range(0, 1) == 0) pend[g] = 1'b0;
      else pcct[g] = pick();
      for (int j = 0; j < N; j++)
         if (j != g && !pend[j] && $urandom_range(0, 2) == 0) begin
            pend[j] = 1'b1;
            pcct[j] = pick();
         end
      cache_flush = fl_lookup;
      drive();
      #1;
      chk("lookup_busy", busy, 1);
      chk("lookup_ready", req_ready, 0);
      chk("lookup_launch", conv_cct_valid, 0);
      if (fl_lookup) m_cv = 0;
      @(negedge clk);
      cache_flush = 1'b0;
      #1;
      if (hit) begin
         chk("hit_rsp", rsp_valid, oh);
         chk("hit_launch", conv_cct_valid, 0);
         chk("hit_x", rsp_xyz_x, m_cx);
         chk("hit_y", rsp_xyz_y, m_cy);
         chk("hit_z", rsp_xyz_z, m_cz);
         chk("hit_to", rsp_timeout, 0);
         return;
      end
      chk("launch", conv_cct_valid, 1);
      chk("launch_cct", conv_cct_out, c);
      chk("launch_rsp", rsp_valid, 0);
      got = (delay < TO);
      last_k = got ? delay : TO - 1;
      sx = $urandom; sy = $urandom; sz = $urandom;
      for (int k = 0; k <= last_k; k++) begin
         @(negedge clk);
         if (k == delay) begin
            conv_xyz_valid = 1'b1;
            conv_xyz_x = sx; conv_xyz_y = sy; conv_xyz_z = sz;
            cache_flush = fl_fill;
         end
         #1;
         chk("wait_rsp", rsp_valid, 0);
         chk("wait_launch", conv_cct_valid, 0);
      end
      @(negedge clk);
      conv_xyz_valid = late;
      conv_xyz_x = $urandom; conv_xyz_y = $urandom; conv_xyz_z = $urandom;
      cache_flush = 1'b0;
      #1;
      chk("resp_valid", rsp_valid, oh);
      if (got) begin
         chk("resp_x", rsp_xyz_x, sx);
         chk("resp_y", rsp_xyz_y, sy);
         chk("resp_z", rsp_xyz_z, sz);
         chk("resp_to", rsp_timeout, 0);
         m_cx = sx; m_cy = sy; m_cz = sz;
         m_ccct = c;
         m_cv = !fl_fill;
      end else begin
         chk("tmo_x", rsp_xyz_x, 0);
         chk("tmo_y", rsp_xyz_y, 0);
         chk("tmo_z", rsp_xyz_z, 0);
         chk("tmo_flag", rsp_timeout, 1);
         m_cv = 0;
      end
   endtask

   initial begin
      int d, r;
      rst = 1'b1;
      pend = '0;
      for (int i = 0; i < N; i++) pcct[i] = '0;
      drive();
      cache_flush = 1'b0;
      conv_xyz_valid = 1'b0;
      conv_xyz_x = '0; conv_xyz_y = '0; conv_xyz_z = '0;
      model_reset();
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rsp", rsp_valid, 0);
      chk("rst_launch", conv_cct_valid, 0);
      chk("rst_cct", conv_cct_out, 0);
      chk("rst_to", rsp_timeout, 0);
      chk("rst_x", rsp_xyz_x, 0);

      pend = 3'b001; pcct[0] = 16'd5000;
      do_txn(9, 0, 0, 0, 0);
      pend = 3'b001; pcct[0] = 16'd5000;
      do_txn(3, 0, 0, 0, 0);
      pend = 3'b001; pcct[0] = 16'd5000;
      do_txn(4, 1, 0, 0, 0);

      pend = 3'b111; pcct[0] = 16'd3000; pcct[1] = 16'd6500; pcct[2] = 16'd8000;
      repeat (4) begin
         pend = 3'b111;
         do_txn(2, 0, 0, 0, 0);
      end

      pend = 3'b010; pcct[1] = 16'd2500;
      do_txn(5, 0, 0, 0, 1);
      pend = 3'b100; pcct[2] = 16'd9000;
      do_txn(5, 0, 0, 0, 1);
      pend = 3'b001; pcct[0] = 16'd3000;
      do_txn(5, 0, 0, 0, 1);

      pend = 3'b001; pcct[0] = 16'd4321;
      do_txn(1000, 0, 0, 1, 1);
      pend = 3'b001; pcct[0] = 16'd4321;
      do_txn(2, 0, 0, 0, 1);

      pend = 3'b001; pcct[0] = 16'd4444;
      do_txn(TO - 1, 0, 0, 0, 1);
      pend = 3'b001; pcct[0] = 16'd4555;
      do_txn(6, 0, 1, 0, 1);
      pend = 3'b001; pcct[0] = 16'd4555;
      do_txn(6, 0, 0, 0, 1);

      for (int t = 0; t < 150; t++) begin
         r = $urandom_range(0, 9);
         d = (r < 6) ? $urandom_range(0, 12) : (r == 6) ? TO - 1 : (r == 7) ? TO :
             (r == 8) ? 0 : 200;
         do_txn(d, $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0,
                $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
      end

      @(negedge clk);
      conv_xyz_valid = 1'b0;
      cache_flush = 1'b0;
      pend = 3'b100; pcct[2] = 16'd6000;
      drive();
      #1;
      chk("mid_ready", req_ready, 3'b001 << rr(pend, m_last));
      @(negedge clk);
      pend = '0;
      drive();
      repeat (4) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_launch", conv_cct_valid, 0);
      chk("arst_cct", conv_cct_out, 0);
      chk("arst_rsp", rsp_valid, 0);
      chk("arst_x", rsp_xyz_x, 0);
      chk("arst_y", rsp_xyz_y, 0);
      chk("arst_z", rsp_xyz_z, 0);
      chk("arst_to", rsp_timeout, 0);
      chk("arst_ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      model_reset();
      @(negedge clk);
      conv_xyz_valid = 1'b1;
      #1;
      chk("late_busy", busy, 0);
      pend = 3'b100; pcct[2] = 16'd6000;
      do_txn(5, 0, 0, 0, 0);
      pend = 3'b100; pcct[2] = 16'd6000;
      do_txn(5, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/cct_xyz_scheduler.md
# cct_xyz_scheduler

Shares one `cct_to_xyz_converter` among up to `NUM_REQ` CCT requesters, such as the ambient-sensor path, user override and calibration, using round-robin arbitration.
- Clamps each granted CCT, then either launches the converter or answers from a one-entry result cache.
- Watches the converter with a timeout and returns the Q16.16 XYZ triple to the granted requester.
- Sits directly upstream of the converter and is the only block that drives its `cct_in`/`cct_valid`.

## Interface
Parameters:
- `NUM_REQ`, 3: number of requesters (2..8).
- `TIMEOUT`, 64: maximum WAIT cycles before abort.
- `CCT_MIN`, 3000: lower clamp, in K.
- `CCT_MAX`, 8000: upper clamp, in K.

Ports (reset is asynchronous, active-high):
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_cct`  in  NUM_REQ*16  packed CCTs; requester i uses bits [16i+15:16i].
- `req_ready`  out  NUM_REQ  one-hot accept, combinational.
- `cache_flush`  in  1  invalidates the result cache.
- `conv_cct_out`  out  16  registered clamped CCT to the converter.
- `conv_cct_valid`  out  1  one-cycle launch pulse.
- `conv_xyz_x`, `conv_xyz_y`, `conv_xyz_z`  in  32 each  converter result, Q16.16.
- `conv_xyz_valid`  in  1  converter result strobe.
- `rsp_valid`  out  NUM_REQ  one-hot one-cycle response strobe.
- `rsp_xyz_x`, `rsp_xyz_y`, `rsp_xyz_z`  out  32 each  registered response data.
- `rsp_timeout`  out  1  qualifies `rsp_valid`: conversion aborted.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, LOOKUP, ISSUE, WAIT, RESP.
- **IDLE:** round-robin grant.
  - Search starts at `last_grant+1` and wraps modulo NUM_REQ; the first asserted `req_valid` wins.
  - `req_ready[g]` is high only in IDLE, only for the winner.
  - On handshake, latch g and clamped CCT = min(max(req_cct[g], CCT_MIN), CCT_MAX); set `last_grant`=g; go to LOOKUP.
- **LOOKUP:**
  - Cache hit (cache_valid and clamped CCT == cache_cct): load response regs from cache, go to RESP.
  - Otherwise go to ISSUE.
- **ISSUE:** `conv_cct_out` <= clamped CCT, `conv_cct_valid` = 1 for exactly this cycle, timeout counter cleared, go to WAIT.
- **WAIT:** counter increments each cycle.
  - On `conv_xyz_valid`: capture X/Y/Z into response regs and cache, set cache_cct and cache_valid, `rsp_timeout`=0, go to RESP.
  - If the counter reaches TIMEOUT-1 without valid: response regs = 0, `rsp_timeout`=1, cache_valid=0, go to RESP.
- **RESP:** `rsp_valid[g]`=1 for one cycle, go to IDLE. Response data and `rsp_timeout` hold until the next RESP.
- Requesters hold `req_valid`/`req_cct` stable until `req_ready`. A requester may deassert before being granted without effect.

## Timing
Reset values:
- All outputs 0; `conv_cct_out`=0.
- State IDLE, cache_valid=0, counter=0.
- `last_grant`=NUM_REQ-1, so requester 0 wins first.

Latency, with handshake in cycle T:
- Cache hit: LOOKUP at T+1, `rsp_valid` at T+2.
- Miss: `conv_cct_valid` at T+2, WAIT from T+3. With `conv_xyz_valid` in cycle W, `rsp_valid` is at W+1.
- Timeout: `rsp_valid` at T+3+TIMEOUT.

Boundary cases:
- `conv_xyz_valid` outside WAIT is ignored; no cache update.
- `conv_xyz_valid` in the same cycle as the final timeout count: valid wins and no timeout is reported.
- `cache_flush` has priority over a same-cycle cache fill, leaving cache_valid=0, but the response data is still delivered. A flush during LOOKUP forces a miss.
- Clamp edges: 2999→3000, 3000→3000, 8000→8000, 8001→8000, 0→3000, 65535→8000.
- Requests arriving while busy wait; no queue beyond `req_valid` holding.
- After RESP, the state is IDLE at RESP+1, so back-to-back grants are 1 cycle apart.
- `rst` mid-operation forces the reset values immediately and asynchronously. A converter result arriving later is ignored.

## Test plan
1. Reset, then req0 at CCT 5000 with a stub converter answering 10 cycles after launch → `conv_cct_out`=5000 with a single `conv_cct_valid` pulse; `rsp_valid`=3'b001 one cycle after `conv_xyz_valid`; data equals the stub data and `rsp_timeout`=0.
2. req0 5000 again → no `conv_cct_valid`; `rsp_valid` 2 cycles after handshake with the cached XYZ. Then `cache_flush` followed by req0 5000 → converter relaunched.
3. All three requesters continuously valid with CCTs 3000/6500/8000 → grants 0,1,2,0,... Each `rsp_valid` is one-hot and matches its requester's CCT.
4. Clamping: req1 at 2500 → `conv_cct_out`=3000. Then req2 at 9000 → 8000. Then req0 at 3000 → cache miss, because the cache holds 8000.
5. Converter stub silent with TIMEOUT=64 → `rsp_valid` at T+67 with `rsp_timeout`=1 and XYZ=0. A late `conv_xyz_valid` is ignored, and the next identical CCT misses the cache.
6. Assert `rst` during WAIT → all outputs 0 asynchronously. After release, a fresh req2 is granted and completes normally.
